// File: rtl/lsu_pipe.sv
// Pipelined load/store unit: valid/ready request side, req/gnt/rvalid memory side, in-order loads.
// Build option LSU_MISALIGN_TRAP_EN: trap misaligned ops instead of truncating their offset.

package lsu_pipe_pkg;
  typedef enum logic [2:0] {
    LdLb  = 3'd0,
    LdLh  = 3'd1,
    LdLw  = 3'd2,
    LdLbu = 3'd3,
    LdLhu = 3'd4
  } load_op_t;

  typedef enum logic [1:0] {
    StSb = 2'd0,
    StSh = 2'd1,
    StSw = 2'd2
  } store_op_t;
endpackage

module lsu_pipe
  import lsu_pipe_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_load,
  input  logic        req_is_store,
  input  load_op_t    load_op,
  input  store_op_t   store_op,
  input  logic [4:0]  rd,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic        ld_valid,
  output logic [4:0]  ld_rd,
  output logic [31:0] ld_rd_data,
  output logic        exc_valid,
  output logic [31:0] exc_addr,
  output logic        exc_store,
  output logic        busy,
  output logic        d_req,
  input  logic        d_gnt,
  output logic [31:0] d_addr,
  output logic [3:0]  d_we,
  output logic [31:0] d_wr_data,
  input  logic        d_rvalid,
  input  logic [31:0] d_rd_data
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DepthCnt = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LastPtr  = PTR_W'(DEPTH - 1);

  typedef struct packed {
    logic [4:0] rd;
    load_op_t   op;
    logic [1:0] off;
  } entry_t;

  logic             mis;
  logic [1:0]       ld_off, st_off;
  logic             is_ld, is_st, not_full, push, pop;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  entry_t           fifo_q [DEPTH];
  entry_t           head;
  logic [31:0]      shifted, ld_data;
  logic             ld_valid_q, busy_q;
  logic [4:0]       ld_rd_q;
  logic [31:0]      ld_rd_data_q;

  // Misalignment detection (trap build) or natural-alignment truncation (default build).
  always_comb begin
    mis    = 1'b0;
    ld_off = addr[1:0];
    st_off = addr[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
    if (req_is_load) begin
      case (load_op)
        LdLh, LdLhu: mis = addr[0];
        LdLw:        mis = |addr[1:0];
        default:     mis = 1'b0;
      endcase
    end else if (req_is_store) begin
      case (store_op)
        StSh:    mis = addr[0];
        StSw:    mis = |addr[1:0];
        default: mis = 1'b0;
      endcase
    end
`else
    case (load_op)
      LdLh, LdLhu: ld_off = {addr[1], 1'b0};
      LdLw:        ld_off = 2'b00;
      default:     ld_off = addr[1:0];
    endcase
    case (store_op)
      StSh:    st_off = {addr[1], 1'b0};
      StSw:    st_off = 2'b00;
      default: st_off = addr[1:0];
    endcase
`endif
  end

  assign not_full = (count_q < DepthCnt);
  assign is_ld    = req_valid & req_is_load & ~mis;
  assign is_st    = req_valid & req_is_store & ~mis;
  assign d_req    = (is_ld & not_full) | is_st;
  assign d_addr   = {addr[31:2], 2'b00};
  assign push     = is_ld & not_full & d_gnt;
  assign pop      = d_rvalid & (count_q != '0);

  // Misaligned and non-memory ops are swallowed immediately.
  always_comb begin
    req_ready = 1'b1;
    if (req_is_load && !mis) begin
      req_ready = d_gnt & not_full;
    end else if (req_is_store && !mis) begin
      req_ready = d_gnt;
    end
  end

  always_comb begin
    d_we      = 4'b0000;
    d_wr_data = write_data;
    case (store_op)
      StSb: begin
        d_wr_data = {4{write_data[7:0]}};
        if (is_st) d_we = 4'b0001 << st_off;
      end
      StSh: begin
        d_wr_data = {2{write_data[15:0]}};
        if (is_st) d_we = 4'b0011 << st_off;
      end
      default: begin
        d_wr_data = write_data;
        if (is_st) d_we = 4'b1111;
      end
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= '{rd: rd, op: load_op, off: ld_off};
    end
  end

  // Pointers wrap explicitly so non-power-of-two depths work.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      busy_q  <= (count_d != '0);
      if (push) wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PTR_W'(1);
    end
  end

  assign head    = fifo_q[rd_ptr_q];
  assign shifted = d_rd_data >> {head.off, 3'b000};

  always_comb begin
    ld_data = shifted;
    case (head.op)
      LdLb:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
      LdLh:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
      LdLbu:   ld_data = {24'b0, shifted[7:0]};
      LdLhu:   ld_data = {16'b0, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_valid_q   <= 1'b0;
      ld_rd_q      <= '0;
      ld_rd_data_q <= '0;
    end else begin
      ld_valid_q <= pop;
      if (pop) begin
        ld_rd_q      <= head.rd;
        ld_rd_data_q <= ld_data;
      end
    end
  end

  assign ld_valid   = ld_valid_q;
  assign ld_rd      = ld_rd_q;
  assign ld_rd_data = ld_rd_data_q;
  assign busy       = busy_q;

`ifdef LSU_MISALIGN_TRAP_EN
  logic        exc_valid_q, exc_store_q;
  logic [31:0] exc_addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      exc_valid_q <= 1'b0;
      exc_addr_q  <= '0;
      exc_store_q <= 1'b0;
    end else begin
      exc_valid_q <= req_valid & mis;
      if (req_valid && mis) begin
        exc_addr_q  <= addr;
        exc_store_q <= req_is_store;
      end
    end
  end

  assign exc_valid = exc_valid_q;
  assign exc_addr  = exc_addr_q;
  assign exc_store = exc_store_q;
`else
  assign exc_valid = 1'b0;
  assign exc_addr  = '0;
  assign exc_store = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_pipe.sv
// Self-checking bench for lsu_pipe: directed vectors, corner sequences, randomized model compare.
module tb_lsu_pipe;
  import lsu_pipe_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, req_is_load, req_is_store;
  load_op_t    load_op;
  store_op_t   store_op;
  logic [4:0]  rd, ld_rd;
  logic [31:0] addr, write_data, ld_rd_data, exc_addr, d_addr, d_wr_data, d_rd_data;
  logic        ld_valid, exc_valid, exc_store, busy, d_req, d_gnt, d_rvalid;
  logic [3:0]  d_we;

  int errors = 0;
  int checks = 0;

  lsu_pipe #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_is_load(req_is_load), .req_is_store(req_is_store), .load_op(load_op),
    .store_op(store_op), .rd(rd), .addr(addr), .write_data(write_data),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_rd_data(ld_rd_data), .exc_valid(exc_valid),
    .exc_addr(exc_addr), .exc_store(exc_store), .busy(busy), .d_req(d_req), .d_gnt(d_gnt),
    .d_addr(d_addr), .d_we(d_we), .d_wr_data(d_wr_data), .d_rvalid(d_rvalid),
    .d_rd_data(d_rd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 0; req_is_load = 0; req_is_store = 0; load_op = LdLw; store_op = StSw;
    rd = 0; addr = 0; write_data = 0; d_gnt = 0; d_rvalid = 0; d_rd_data = 0;
  endtask

  task automatic drive_load(input load_op_t op, input logic [4:0] r, input logic [31:0] a);
    req_valid = 1; req_is_load = 1; req_is_store = 0; load_op = op; rd = r; addr = a; d_gnt = 1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  // Reference model helpers, phrased as access sizes and byte positions.
  function automatic int ld_size(input load_op_t op);
    case (op)
      LdLb, LdLbu: return 1;
      LdLh, LdLhu: return 2;
      default:     return 4;
    endcase
  endfunction

  function automatic int st_size(input store_op_t op);
    case (op)
      StSb:    return 1;
      StSh:    return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit model_mis(input int sz, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
    return (a % sz) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] ld_extract(input load_op_t op, input int off,
                                             input logic [31:0] w);
    longint unsigned v, wide;
    int sz;
    sz   = ld_size(op);
    wide = {32'b0, w};
    v    = (wide >> (8 * off)) & ((64'd1 << (8 * sz)) - 1);
    if ((op == LdLb || op == LdLh) && v >= (64'd1 << (8 * sz - 1)))
      v = v + (64'hFFFF_FFFF << (8 * sz));
    return v[31:0];
  endfunction

  typedef struct {
    bit          is_store;
    load_op_t    lop;
    store_op_t   sop;
    logic [31:0] a;
    logic [31:0] data;
    logic [3:0]  exp_we;
    logic [31:0] exp_val;
  } vec_t;

  typedef struct {
    logic [4:0] rd;
    load_op_t   op;
    int         off;
  } pend_t;

  vec_t  vecs[10];
  pend_t q[$];

  initial begin
    vecs[0] = '{1'b1, LdLb,  StSb, 32'h203, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5};
    vecs[1] = '{1'b1, LdLb,  StSh, 32'h202, 32'h0000_1234, 4'b1100, 32'h1234_1234};
    vecs[2] = '{1'b1, LdLb,  StSw, 32'h200, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D};
    vecs[3] = '{1'b1, LdLb,  StSb, 32'h000, 32'h0000_0077, 4'b0001, 32'h7777_7777};
    vecs[4] = '{1'b0, LdLb,  StSb, 32'h001, 32'h0000_8000, 4'b0000, 32'hFFFF_FF80};
    vecs[5] = '{1'b0, LdLbu, StSb, 32'h001, 32'h0000_8000, 4'b0000, 32'h0000_0080};
    vecs[6] = '{1'b0, LdLhu, StSb, 32'h002, 32'hBEEF_0000, 4'b0000, 32'h0000_BEEF};
    vecs[7] = '{1'b0, LdLh,  StSb, 32'h002, 32'hBEEF_0000, 4'b0000, 32'hFFFF_BEEF};
    vecs[8] = '{1'b0, LdLw,  StSb, 32'h004, 32'h7FFF_1234, 4'b0000, 32'h7FFF_1234};
    vecs[9] = '{1'b0, LdLb,  StSb, 32'h003, 32'h7F00_0000, 4'b0000, 32'h0000_007F};

    rst = 1;
    idle();
    do_reset();
    chk("reset_ld_valid", ld_valid, 0);
    chk("reset_ld_rd", ld_rd, 0);
    chk("reset_ld_rd_data", ld_rd_data, 0);
    chk("reset_exc_valid", exc_valid, 0);
    chk("reset_exc_addr", exc_addr, 0);
    chk("reset_exc_store", exc_store, 0);
    chk("reset_busy", busy, 0);

    // LW latency: accept at T, rvalid at T+3, writeback at T+4.
    drive_load(LdLw, 5, 32'h100);
    #1;
    chk("lw_ready", req_ready, 1);
    chk("lw_d_req", d_req, 1);
    chk("lw_d_addr", d_addr, 32'h100);
    chk("lw_d_we", d_we, 0);
    tick();
    idle();
    chk("lw_busy", busy, 1);
    tick();
    tick();
    d_rvalid = 1; d_rd_data = 32'hDEAD_BEEF;
    #1;
    chk("lw_not_early", ld_valid, 0);
    tick();
    idle();
    chk("lw_ld_valid", ld_valid, 1);
    chk("lw_ld_rd", ld_rd, 5);
    chk("lw_ld_rd_data", ld_rd_data, 32'hDEAD_BEEF);
    chk("lw_busy_clear", busy, 0);
    tick();
    chk("lw_pulse", ld_valid, 0);
    chk("lw_hold_rd", ld_rd, 5);
    chk("lw_hold_data", ld_rd_data, 32'hDEAD_BEEF);

    for (int i = 0; i < 10; i++) begin
      idle();
      if (vecs[i].is_store) begin
        req_valid = 1; req_is_store = 1; store_op = vecs[i].sop; addr = vecs[i].a;
        write_data = vecs[i].data; d_gnt = 1;
        #1;
        chk($sformatf("vec%0d_st_ready", i), req_ready, 1);
        chk($sformatf("vec%0d_st_d_req", i), d_req, 1);
        chk($sformatf("vec%0d_st_d_addr", i), d_addr, {vecs[i].a[31:2], 2'b00});
        chk($sformatf("vec%0d_st_d_we", i), d_we, vecs[i].exp_we);
        chk($sformatf("vec%0d_st_wdata", i), d_wr_data, vecs[i].exp_val);
        tick();
        chk($sformatf("vec%0d_st_busy", i), busy, 0);
      end else begin
        drive_load(vecs[i].lop, 5'(10 + i), vecs[i].a);
        #1;
        chk($sformatf("vec%0d_ld_ready", i), req_ready, 1);
        tick();
        idle();
        d_rvalid = 1; d_rd_data = vecs[i].data;
        tick();
        idle();
        chk($sformatf("vec%0d_ld_valid", i), ld_valid, 1);
        chk($sformatf("vec%0d_ld_rd", i), ld_rd, 32'(10 + i));
        chk($sformatf("vec%0d_ld_data", i), ld_rd_data, vecs[i].exp_val);
      end
    end

    // Fill the FIFO, check backpressure, stores still flow, in-order drain.
    idle();
    for (int i = 1; i <= DEPTH; i++) begin
      drive_load(LdLw, 5'(i), 32'(32'h40 * i));
      #1;
      chk($sformatf("fill%0d_ready", i), req_ready, 1);
      tick();
    end
    drive_load(LdLw, 5, 32'h500);
    #1;
    chk("full_ready", req_ready, 0);
    chk("full_d_req", d_req, 0);
    req_is_load = 0; req_is_store = 1; store_op = StSw; addr = 32'h300; write_data = 32'h1;
    #1;
    chk("full_store_ready", req_ready, 1);
    chk("full_store_d_req", d_req, 1);
    tick();
    for (int k = 1; k <= DEPTH; k++) begin
      idle();
      if (k == 1) drive_load(LdLw, 5, 32'h500);
      d_rvalid = 1; d_rd_data = 32'(32'h1111_1111 * k);
      #1;
      if (k == 1) chk("full_pop_ready", req_ready, 0);
      tick();
      chk($sformatf("drain%0d_valid", k), ld_valid, 1);
      chk($sformatf("drain%0d_rd", k), ld_rd, 32'(k));
      chk($sformatf("drain%0d_data", k), ld_rd_data, 32'(32'h1111_1111 * k));
    end
    idle();
    drive_load(LdLw, 5, 32'h500);
    #1;
    chk("fifth_ready", req_ready, 1);
    tick();
    idle();
    d_rvalid = 1; d_rd_data = 32'h5555_5555;
    tick();
    idle();
    chk("fifth_rd", ld_rd, 5);
    chk("fifth_busy", busy, 0);

    // Misaligned word load.
    drive_load(LdLw, 7, 32'h102);
    #1;
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_ready", req_ready, 1);
    chk("mis_d_req", d_req, 0);
    tick();
    idle();
    chk("mis_exc_valid", exc_valid, 1);
    chk("mis_exc_addr", exc_addr, 32'h102);
    chk("mis_exc_store", exc_store, 0);
    chk("mis_no_push", busy, 0);
    req_valid = 1; req_is_store = 1; store_op = StSh; addr = 32'h205; d_gnt = 1;
    #1;
    chk("mis_st_d_we", d_we, 0);
    chk("mis_st_d_req", d_req, 0);
    tick();
    idle();
    chk("mis_st_exc_store", exc_store, 1);
    chk("mis_st_exc_addr", exc_addr, 32'h205);
`else
    chk("trunc_ready", req_ready, 1);
    chk("trunc_d_req", d_req, 1);
    chk("trunc_d_addr", d_addr, 32'h100);
    tick();
    idle();
    chk("trunc_busy", busy, 1);
    d_rvalid = 1; d_rd_data = 32'h1122_3344;
    tick();
    idle();
    chk("trunc_ld_valid", ld_valid, 1);
    chk("trunc_ld_data", ld_rd_data, 32'h1122_3344);
    chk("trunc_exc_valid", exc_valid, 0);
    req_valid = 1; req_is_store = 1; store_op = StSh; addr = 32'h203; d_gnt = 1;
    #1;
    chk("trunc_sh_we", d_we, 4'b1100);
    tick();
    idle();
`endif

    // Reset with loads in flight: stale responses must be dropped.
    for (int i = 0; i < 2; i++) begin
      drive_load(LdLw, 5'(20 + i), 32'h600);
      tick();
    end
    idle();
    rst = 1;
    tick();
    rst = 0;
    chk("rst_busy", busy, 0);
    for (int i = 0; i < 2; i++) begin
      d_rvalid = 1; d_rd_data = 32'hBAD0_0000;
      tick();
      idle();
      chk($sformatf("stale%0d_valid", i), ld_valid, 0);
      chk($sformatf("stale%0d_busy", i), busy, 0);
    end
    for (int i = 0; i < DEPTH; i++) begin
      drive_load(LdLw, 5'(i), 32'h700);
      #1;
      chk($sformatf("post_rst_ready%0d", i), req_ready, 1);
      tick();
    end

    // Randomized run against the queue model.
    do_reset();
    q.delete();
    begin
      bit          exp_ldv, exp_excv, exp_excs, full, mis, acc_ld;
      logic [4:0]  exp_rd;
      logic [31:0] exp_data, exp_exca, exp_wdata;
      logic [3:0]  exp_we;
      bit          exp_dreq, exp_ready;
      int          kind, sz, off;
      pend_t       e;
      exp_ldv = 0; exp_excv = 0; exp_excs = 0; exp_rd = 0; exp_data = 0; exp_exca = 0;
      for (int c = 0; c < 2000; c++) begin
        kind         = $urandom_range(0, 7);
        req_valid    = ($urandom_range(0, 3) != 0);
        req_is_load  = (kind >= 1 && kind <= 4);
        req_is_store = (kind >= 5);
        load_op      = load_op_t'($urandom_range(0, 4));
        store_op     = store_op_t'($urandom_range(0, 2));
        rd           = 5'($urandom);
        addr         = $urandom;
        write_data   = $urandom;
        d_gnt        = ($urandom_range(0, 3) != 0);
        d_rvalid     = (q.size() > 0) ? ($urandom_range(0, 4) < 2) : ($urandom_range(0, 9) == 0);
        d_rd_data    = $urandom;
        #1;
        full = (q.size() >= DEPTH);
        sz   = req_is_load ? ld_size(load_op) : st_size(store_op);
        mis  = (req_is_load || req_is_store) && model_mis(sz, addr);
        off  = (addr % 4) - ((addr % 4) % sz);
        exp_dreq  = req_valid && !mis && ((req_is_load && !full) || req_is_store);
        exp_ready = (!req_is_load && !req_is_store) || mis ||
                    (req_is_load ? (d_gnt && !full) : d_gnt);
        exp_we    = 0;
        exp_wdata = 0;
        if (req_valid && req_is_store && !mis) begin
          for (int b = 0; b < 4; b++) begin
            if (b >= off && b < off + sz) exp_we[b] = 1'b1;
            exp_wdata[8*b +: 8] = write_data[8*(b % sz) +: 8];
          end
        end
        chk("rnd_d_req", d_req, exp_dreq);
        if (req_valid) chk("rnd_req_ready", req_ready, exp_ready);
        chk("rnd_d_we", d_we, exp_we);
        if (exp_we != 0) chk("rnd_d_wr_data", d_wr_data, exp_wdata);
        if (exp_dreq) chk("rnd_d_addr", d_addr, addr & 32'hFFFF_FFFC);
        exp_ldv = 0;
        if (d_rvalid && q.size() > 0) begin
          e        = q.pop_front();
          exp_ldv  = 1;
          exp_rd   = e.rd;
          exp_data = ld_extract(e.op, e.off, d_rd_data);
        end
        acc_ld = req_valid && req_is_load && !mis && !full && d_gnt;
        if (acc_ld) q.push_back('{rd, load_op, off});
        exp_excv = req_valid && mis;
        if (exp_excv) begin
          exp_exca = addr;
          exp_excs = req_is_store;
        end
        tick();
        chk("rnd_ld_valid", ld_valid, exp_ldv);
        chk("rnd_ld_rd", ld_rd, exp_rd);
        chk("rnd_ld_rd_data", ld_rd_data, exp_data);
        chk("rnd_busy", busy, q.size() != 0);
        chk("rnd_exc_valid", exc_valid, exp_excv);
        chk("rnd_exc_addr", exc_addr, exp_exca);
        chk("rnd_exc_store", exc_store, exp_excs);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_pipe.md
Name: lsu_pipe

Overview:
- Pipelined load/store unit for the tiny-riscv core. It replaces the fixed one-cycle LSU with a valid/ready request interface and a variable-latency data-memory port using req/gnt/rvalid.
- Up to DEPTH loads may be outstanding; their responses return in order.
- Sub-word accesses are byte-lane steered by addr[1:0].
- Sits between execute/control and data memory. Control uses busy and the ld_* writeback for hazard decisions.

Parameters:
- DEPTH, 4, max outstanding loads (tag FIFO entries), >=1.
- CNT_W, $clog2(DEPTH+1), derived, width of the occupancy counter. Not overridden.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  core presents a memory op
- req_ready  out  1  op accepted this cycle when req_valid&req_ready
- req_is_load  in  1  op is a load
- req_is_store  in  1  op is a store (never both with req_is_load)
- load_op  in  load_op_t  LB/LH/LW/LBU/LHU
- store_op  in  store_op_t  SB/SH/SW
- rd  in  5  load destination register
- addr  in  32  byte address
- write_data  in  32  store data, right-justified
- ld_valid  out  1  load writeback valid, one-cycle pulse
- ld_rd  out  5  writeback register
- ld_rd_data  out  32  extended load data
- exc_valid  out  1  misaligned-access pulse
- exc_addr  out  32  faulting address
- exc_store  out  1  faulting op was a store
- busy  out  1  one or more loads outstanding
- d_req  out  1  memory request
- d_gnt  in  1  memory accepts request this cycle
- d_addr  out  32  word address {addr[31:2],2'b00}
- d_we  out  4  byte write enables (0 for loads)
- d_wr_data  out  32  lane-replicated store data
- d_rvalid  in  1  load response, in order, >=1 cycle after grant
- d_rd_data  in  32  response word

Behaviour:
- Reset (synchronous, rst=1 at posedge): FIFO emptied, count=0. ld_valid, exc_valid, exc_store=0. ld_rd, ld_rd_data, exc_addr=0. busy=0.
- Misaligned: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
- Aligned load path: d_req=req_valid&req_is_load&(count<DEPTH). req_ready=d_gnt&(count<DEPTH).
- Aligned store path: d_req=req_valid&req_is_store. req_ready=d_gnt. Stores are not blocked by a full FIFO.
- Misaligned op: d_req=0 and req_ready=1. The op is accepted without a memory access. Next cycle: exc_valid=1, exc_addr=addr, exc_store=req_is_store.
- req_valid with neither is_load nor is_store: req_ready=1, no other effect.
- d_we is zero unless the op is an aligned store.
- d_we per store_op: SB 4'b0001<<addr[1:0]; SH 4'b0011<<addr[1:0]; SW 4'b1111.
- d_wr_data per store_op: SB {4{wd[7:0]}}; SH {2{wd[15:0]}}; SW wd.
- Load accept: push {rd, load_op, addr[1:0]} to the FIFO; count+1.
- d_rvalid with FIFO non-empty: pop the head.
  - Next cycle ld_valid=1 and ld_rd=head.rd.
  - ld_rd_data = d_rd_data>>(8*offset), then sign- or zero-extended per head.load_op.
  - Latency: load accepted in cycle T, d_rvalid in T+L, ld_valid in T+L+1.
- d_rvalid with FIFO empty: ignored, no ld_valid. This covers responses from before a reset.
- Push and pop in the same cycle: count unchanged. Legal when full, but req_ready still uses the pre-pop count.
- Pointers wrap modulo DEPTH; any DEPTH is supported, not only powers of two.
- busy=(count!=0), registered.
- ld_rd and ld_rd_data hold their last value while ld_valid=0.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: misaligned handling as above, exc_* active.
- Undefined: no misalignment check. The offset is truncated to natural alignment (halfword addr[0] forced to 0; word addr[1:0] forced to 0) and the op proceeds normally. exc_valid, exc_addr and exc_store are tied to 0.

Test Plan:
- Reset, then LW rd=5 addr=0x100; mem grants at once, rvalid 3 cycles later with 0xDEADBEEF -> ld_valid=1, ld_rd=5, ld_rd_data=0xDEADBEEF exactly 1 cycle after rvalid; busy 1->0.
- SB wd=0x000000A5 addr=0x203 -> d_addr=0x200, d_we=4'b1000, d_wr_data=0xA5A5A5A5.
- SH at addr=0x202 -> d_we=4'b1100.
- LB addr=0x1 with response 0x00008000 -> ld_rd_data=0xFFFFFF80.
- LBU at the same address and response -> ld_rd_data=0x00000080.
- LHU addr=0x2 with response 0xBEEF0000 -> ld_rd_data=0x0000BEEF.
- DEPTH=4: issue 5 back-to-back loads with no rvalid -> 5th sees req_ready=0 while d_gnt=1. Stores are still accepted. Returning rvalids pop in issue order with rd 1,2,3,4, and the 5th load is then accepted.
- With LSU_MISALIGN_TRAP_EN: LW addr=0x102 -> req_ready=1, d_req=0, next cycle exc_valid=1, exc_addr=0x102, exc_store=0; no FIFO push.
- Without the macro: same op -> d_addr=0x100 and a normal load completes.
- Issue 2 loads, assert rst before responses, then drive 2 rvalids -> no ld_valid, busy=0, count=0.
